// File: rtl/hazard_ctrl_mc.sv
// Pipeline hazard controller: E/D forwarding, load-use stall, branch/redirect flush, mul/div stall FSM.
// Latency: forwarding/stall/flush outputs are combinational; FSM state and perf counters update on clk.
// Backpressure: a multi-cycle op holds F/D/E for MD_LAT-1 cycles; redirectM overrides every stall.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating perf counters (perf_ldstall/perf_mdstall/perf_flush).

`ifndef NO_FWD
`define NO_FWD  2'b00
`endif
`ifndef FWD_WB
`define FWD_WB  2'b01
`endif
`ifndef FWD_MEM
`define FWD_MEM 2'b10
`endif

module hazard_ctrl_mc #(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int PERF_W = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs1D,
    input  logic [REG_AW-1:0] rs2D,
    input  logic [REG_AW-1:0] rs1E,
    input  logic [REG_AW-1:0] rs2E,
    input  logic [REG_AW-1:0] rdE,
    input  logic [REG_AW-1:0] rdM,
    input  logic [REG_AW-1:0] rdW,
    input  logic              memtoregE,
    input  logic              writesregM,
    input  logic              writesregW,
    input  logic              mdstartE,
    input  logic              branchtakenE,
    input  logic              redirectM,
    output logic [1:0]        forwardAE,
    output logic [1:0]        forwardBE,
    output logic              forwardAD,
    output logic              forwardBD,
    output logic              stallF,
    output logic              stallD,
    output logic              stallE,
    output logic              flushD,
    output logic              flushE,
    output logic              flushM,
    output logic              mdbusy,
    output logic              mddoneE
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_ldstall,
    output logic [PERF_W-1:0] perf_mdstall,
    output logic [PERF_W-1:0] perf_flush
`endif
);

    localparam int CNT_W = $clog2(MD_LAT + 1);
    localparam bit MD_MULTI = (MD_LAT > 1);
    // Counter starts at MD_LAT-2: the IDLE start cycle plus MD_LAT-1 BUSY cycles gives MD_LAT in E.
    localparam logic [CNT_W-1:0] CNT_INIT = MD_MULTI ? CNT_W'(MD_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mdstall;
    logic             loadstall;

    // Operand source select for E: M beats W, register 0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs,
                                           input logic [REG_AW-1:0] rd_m, input logic wr_m,
                                           input logic [REG_AW-1:0] rd_w, input logic wr_w);
        if (rs != '0 && rs == rd_m && wr_m)      return `FWD_MEM;
        else if (rs != '0 && rs == rd_w && wr_w) return `FWD_WB;
        else                                     return `NO_FWD;
    endfunction

    assign forwardAE = fwd_sel(rs1E, rdM, writesregM, rdW, writesregW);
    assign forwardBE = fwd_sel(rs2E, rdM, writesregM, rdW, writesregW);
    assign forwardAD = (rs1D != '0) && (rs1D == rdW) && writesregW;
    assign forwardBD = (rs2D != '0) && (rs2D == rdW) && writesregW;

    assign mdstall   = ((state_q == S_IDLE) && mdstartE && MD_MULTI) ||
                       ((state_q == S_BUSY) && (cnt_q != '0));
    assign mddoneE   = ((state_q == S_IDLE) && mdstartE && !MD_MULTI) ||
                       ((state_q == S_BUSY) && (cnt_q == '0) && !redirectM);
    assign mdbusy    = (state_q == S_BUSY);
    assign loadstall = memtoregE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

    // Stall/flush arbitration: redirect > multi-cycle stall > taken branch > load-use.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (redirectM) begin
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
        end else if (mdstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else if (branchtakenE) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (loadstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Multi-cycle execute sequencer; mdstartE is ignored while BUSY, redirect aborts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mdstartE && !redirectM && MD_MULTI) begin
                        state_q <= S_BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                S_BUSY: begin
                    if (redirectM || (cnt_q == '0)) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0] ld_cnt_q, md_cnt_q, fl_cnt_q;
    // Counters track stalls that actually take effect after arbitration.
    wire ld_evt = loadstall && !redirectM && !mdstall && !branchtakenE;
    wire md_evt = mdstall && !redirectM;
    wire fl_evt = flushD || flushE;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_cnt_q <= '0;
            md_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            if (ld_evt && (ld_cnt_q != '1)) ld_cnt_q <= ld_cnt_q + PERF_W'(1);
            if (md_evt && (md_cnt_q != '1)) md_cnt_q <= md_cnt_q + PERF_W'(1);
            if (fl_evt && (fl_cnt_q != '1)) fl_cnt_q <= fl_cnt_q + PERF_W'(1);
        end
    end

    assign perf_ldstall = ld_cnt_q;
    assign perf_mdstall = md_cnt_q;
    assign perf_flush   = fl_cnt_q;
`endif

endmodule
